// File: rtl/fp_accumulator_multi.sv
// Multi-channel binary32 frame accumulator sharing one pipelined RNE adder (subnormals flushed).
// Define FP_ACC_INF_FLAG_EN to add the per-frame out_inf sticky flag.
module fp_accumulator_multi #(
  parameter  int NUM_CH  = 4,
  parameter  int ADD_LAT = 3,
  localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [CH_W-1:0] in_ch,
  input  logic [31:0]     in_data,
  input  logic            in_last,
  output logic            in_ready,
  output logic            out_valid,
  output logic [CH_W-1:0] out_ch,
  output logic [31:0]     out_data
`ifdef FP_ACC_INF_FLAG_EN
  ,
  output logic            out_inf
`endif
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0]       x, y;
    logic [7:0]        d;
    logic [26:0]       ma, mb, sh, m;
    logic [27:0]       s;
    logic [24:0]       mr;
    logic signed [9:0] e;
    logic              x_nan, y_nan, x_inf, y_inf, x_zero, y_zero;
    // order by magnitude so x is never smaller than y
    if (b[30:0] > a[30:0]) begin
      x = b;
      y = a;
    end else begin
      x = a;
      y = b;
    end
    x_zero = (x[30:23] == 8'h00);
    y_zero = (y[30:23] == 8'h00);
    x_inf  = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
    y_inf  = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);
    x_nan  = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    y_nan  = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
    if (x_nan || y_nan) return QNAN;
    if (x_inf && y_inf) return (x[31] == y[31]) ? x : QNAN;
    if (x_inf) return x;
    if (x_zero && y_zero) return {x[31] & y[31], 31'd0};
    if (y_zero) return x;
    d  = x[30:23] - y[30:23];
    ma = {1'b1, x[22:0], 3'b000};
    mb = {1'b1, y[22:0], 3'b000};
    if (d > 8'd26) begin
      sh = 27'd1;
    end else begin
      sh = mb >> d;
      if ((sh << d) != mb) sh[0] = 1'b1;
    end
    e = $signed({2'b00, x[30:23]});
    s = 28'd0;
    if (x[31] == y[31]) begin
      s = {1'b0, ma} + {1'b0, sh};
      if (s[27]) begin
        m = s[27:1] | {26'd0, s[0]};
        e = e + 10'sd1;
      end else begin
        m = s[26:0];
      end
    end else begin
      m = ma - sh;
      if (m == 27'd0) return 32'h0000_0000;
      for (int i = 0; i < 27; i++) begin
        if (!m[26]) begin
          m = m << 1;
          e = e - 10'sd1;
        end
      end
    end
    mr = {1'b0, m[26:3]} + {24'd0, m[2] & (m[1] | m[0] | m[3])};
    if (mr[24]) begin
      mr = mr >> 1;
      e  = e + 10'sd1;
    end
    if (e >= 10'sd255) return {x[31], 8'hFF, 23'd0};
    if (e <= 10'sd0) return {x[31], 31'd0};
    return {x[31], e[7:0], mr[22:0]};
  endfunction

  logic [31:0]        r_acc [NUM_CH];
  logic [NUM_CH-1:0]  r_first;
  logic [NUM_CH-1:0]  r_busy;
  logic [ADD_LAT-1:0] r_pv;
  logic [ADD_LAT-1:0] r_plast;
  logic [CH_W-1:0]    r_pch [ADD_LAT];
  logic [31:0]        r_psum [ADD_LAT];

  logic              w_ch_ok;
  logic              w_accept;
  logic [31:0]       w_opnd;
  logic [31:0]       w_sum;
  logic              w_wb;
  logic              w_wb_last;
  logic [CH_W-1:0]   w_wb_ch;
  logic [31:0]       w_wb_sum;

  assign w_ch_ok   = 32'(in_ch) < NUM_CH;
  assign in_ready  = ~rst & (~w_ch_ok | ~r_busy[in_ch]);
  assign w_accept  = in_valid & in_ready & w_ch_ok;
  assign w_opnd    = r_first[in_ch] ? 32'h8000_0000 : r_acc[in_ch];
  assign w_sum     = fp_add(in_data, w_opnd);
  assign w_wb      = r_pv[ADD_LAT-1];
  assign w_wb_last = r_plast[ADD_LAT-1];
  assign w_wb_ch   = r_pch[ADD_LAT-1];
  assign w_wb_sum  = r_psum[ADD_LAT-1];

  always_ff @(posedge clk) begin
    r_pch[0]   <= in_ch;
    r_psum[0]  <= w_sum;
    r_plast[0] <= in_last;
    for (int k = 1; k < ADD_LAT; k++) begin
      r_pch[k]   <= r_pch[k-1];
      r_psum[k]  <= r_psum[k-1];
      r_plast[k] <= r_plast[k-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) r_acc[i] <= 32'd0;
      r_first   <= '1;
      r_busy    <= '0;
      r_pv      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= 32'd0;
    end else begin
      r_pv      <= {r_pv[ADD_LAT-2:0], w_accept};
      out_valid <= 1'b0;
      // writeback and accept never target the same channel: accept needs ~busy
      if (w_wb) begin
        r_acc[w_wb_ch]  <= w_wb_sum;
        r_busy[w_wb_ch] <= 1'b0;
        if (w_wb_last) begin
          out_valid        <= 1'b1;
          out_ch           <= w_wb_ch;
          out_data         <= w_wb_sum;
          r_first[w_wb_ch] <= 1'b1;
        end
      end
      if (w_accept) begin
        r_busy[in_ch]  <= 1'b1;
        r_first[in_ch] <= 1'b0;
      end
    end
  end

`ifdef FP_ACC_INF_FLAG_EN
  logic [NUM_CH-1:0] r_inf;
  logic              w_wb_inf;

  assign w_wb_inf = (w_wb_sum[30:23] == 8'hFF);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inf   <= '0;
      out_inf <= 1'b0;
    end else begin
      if (w_accept && r_first[in_ch]) r_inf[in_ch] <= 1'b0;
      if (w_wb) begin
        r_inf[w_wb_ch] <= r_inf[w_wb_ch] | w_wb_inf;
        if (w_wb_last) out_inf <= r_inf[w_wb_ch] | w_wb_inf;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fp_accumulator_multi.sv
// Directed bench for fp_accumulator_multi: frame-sum vector table plus timing/reset sequences.
// With FP_ACC_INF_FLAG_EN defined it also exercises out_inf.
module tb_fp_accumulator_multi;
  localparam int NUM_CH  = 4;
  localparam int ADD_LAT = 3;
  localparam int CH_W    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic [CH_W-1:0] in_ch;
  logic [31:0]     in_data;
  logic            in_last;
  logic            in_ready;
  logic            out_valid;
  logic [CH_W-1:0] out_ch;
  logic [31:0]     out_data;
`ifdef FP_ACC_INF_FLAG_EN
  logic            out_inf;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fp_accumulator_multi #(.NUM_CH(NUM_CH), .ADD_LAT(ADD_LAT)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ch    (in_ch),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_ch   (out_ch),
`ifdef FP_ACC_INF_FLAG_EN
    .out_inf  (out_inf),
`endif
    .out_data (out_data)
  );

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [31:0]     a;
    logic [31:0]     b;
    logic [31:0]     exp_sum;
  } vec_t;

  typedef struct {
    logic [CH_W-1:0] ch;
    logic [31:0]     data;
    logic            inf;
  } out_t;

  vec_t vecs [12];
  out_t q [$];

  always @(negedge clk) begin
    if (out_valid) begin
      out_t o;
      o.ch   = out_ch;
      o.data = out_data;
`ifdef FP_ACC_INF_FLAG_EN
      o.inf  = out_inf;
`else
      o.inf  = 1'b0;
`endif
      q.push_back(o);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CH_W-1:0] ch, input logic [31:0] d, input logic last);
    int n;
    n = 0;
    in_ch    = ch;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b0;
    #1;
    while (!in_ready && n < 20) begin
      step();
      #1;
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout ch%0d: in_ready got 0 want 1", ch);
    end
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_pulse(input string name, input logic [CH_W-1:0] exp_ch,
                            input logic [31:0] exp_data, output logic got_inf);
    int   n;
    out_t o;
    n       = 0;
    got_inf = 1'b0;
    while (q.size() == 0 && n < 30) begin
      step();
      n++;
    end
    if (q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: pulses got 0 want 1", name);
    end else begin
      o       = q.pop_front();
      got_inf = o.inf;
      check({name, "_ch"}, 32'(o.ch), 32'(exp_ch));
      check({name, "_data"}, o.data, exp_data);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic inf;
    vecs[0]  = '{2'd0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000}; // 1 + 2
    vecs[1]  = '{2'd1, 32'h3FC0_0000, 32'hBFC0_0000, 32'h0000_0000}; // exact cancel -> +0
    vecs[2]  = '{2'd2, 32'h4000_0000, 32'hBF00_0000, 32'h3FC0_0000}; // 2 - 0.5
    vecs[3]  = '{2'd3, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000}; // tie -> even
    vecs[4]  = '{2'd0, 32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001}; // above half -> up
    vecs[5]  = '{2'd1, 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000}; // +inf + -inf
    vecs[6]  = '{2'd2, 32'h0000_0001, 32'h0040_0000, 32'h0000_0000}; // subnormals flushed
    vecs[7]  = '{2'd3, 32'h3F80_0000, 32'h0000_0005, 32'h3F80_0000};
    vecs[8]  = '{2'd0, 32'h3F80_0001, 32'hBF80_0000, 32'h3400_0000}; // massive cancel
    vecs[9]  = '{2'd1, 32'h0080_0000, 32'h8080_0001, 32'h8000_0000}; // underflow -> -0
    vecs[10] = '{2'd2, 32'h4040_0000, 32'h7F80_0000, 32'h7F80_0000};
    vecs[11] = '{2'd3, 32'h7F80_0001, 32'h3F80_0000, 32'h7FC0_0000}; // sNaN -> qNaN

    rst      = 1'b1;
    in_valid = 1'b0;
    in_ch    = '0;
    in_data  = 32'd0;
    in_last  = 1'b0;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_ch", 32'(out_ch), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 12; i++) begin
      send(vecs[i].ch, vecs[i].a, 1'b0);
      send(vecs[i].ch, vecs[i].b, 1'b1);
      wait_pulse($sformatf("vec%0d", i), vecs[i].ch, vecs[i].exp_sum, inf);
    end

    // three-sample frame on ch0
    send(2'd0, 32'h3F80_0000, 1'b0);
    send(2'd0, 32'h4000_0000, 1'b0);
    send(2'd0, 32'h4040_0000, 1'b1);
    wait_pulse("seq123", 2'd0, 32'h40C0_0000, inf);
    repeat (ADD_LAT + 2) step();
    check("seq123_single", 32'(q.size()), 32'd0);

    // single-sample -0 frame: pulse timing and hold afterwards
    send(2'd2, 32'h8000_0000, 1'b1);
    repeat (ADD_LAT - 1) step();
    check("neg0_early", 32'(out_valid), 32'd0);
    step();
    check("neg0_valid", 32'(out_valid), 32'd1);
    check("neg0_ch", 32'(out_ch), 32'd2);
    check("neg0_data", out_data, 32'h8000_0000);
    step();
    check("neg0_pulse_end", 32'(out_valid), 32'd0);
    check("neg0_hold_data", out_data, 32'h8000_0000);
    check("neg0_hold_ch", 32'(out_ch), 32'd2);
    step();
    q.delete();

    // four channels interleaved every cycle
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        in_ch    = CH_W'(c);
        in_data  = 32'h3F80_0000;
        in_last  = (r == 3);
        in_valid = 1'b1;
        #1;
        check($sformatf("ilv_ready_r%0d_c%0d", r, c), 32'(in_ready), 32'd1);
        step();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    for (int c = 0; c < 4; c++) wait_pulse($sformatf("ilv%0d", c), CH_W'(c), 32'h4080_0000, inf);

    // ch1 driven back-to-back: busy for ADD_LAT cycles after each accept
    in_ch    = 2'd1;
    in_data  = 32'h3F80_0000;
    in_last  = 1'b0;
    in_valid = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("b2b_ready%0d", k), 32'(in_ready), 32'd1);
      step();
      for (int j = 0; j < ADD_LAT; j++) begin
        check($sformatf("b2b_busy%0d_%0d", k, j), 32'(in_ready), 32'd0);
        step();
      end
    end
    in_last = 1'b1;
    #1;
    check("b2b_ready_last", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_pulse("b2b", 2'd1, 32'h4080_0000, inf);

    // reset while a closing sample is in flight
    send(2'd0, 32'h40A0_0000, 1'b1);
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd0);
    step();
    rst = 1'b0;
    repeat (ADD_LAT + 3) step();
    check("midrst_no_pulse", 32'(q.size()), 32'd0);
    send(2'd0, 32'h3F80_0000, 1'b1);
    wait_pulse("post_rst", 2'd0, 32'h3F80_0000, inf);

`ifdef FP_ACC_INF_FLAG_EN
    send(2'd1, 32'h7F7F_FFFF, 1'b0);
    send(2'd1, 32'h7F7F_FFFF, 1'b1);
    wait_pulse("ovf", 2'd1, 32'h7F80_0000, inf);
    check("ovf_inf", 32'(inf), 32'd1);
    send(2'd1, 32'h3F80_0000, 1'b1);
    wait_pulse("after_ovf", 2'd1, 32'h3F80_0000, inf);
    check("after_ovf_inf", 32'(inf), 32'd0);
`endif

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fp_accumulator_multi.md
FP_ACCUMULATOR_MULTI -- requirements
Module: fp_accumulator_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent accumulation channels (1..16).
REQ-002 SHALL have parameter ADD_LAT, default 3: adder pipeline depth in cycles (2..8).
REQ-003 SHALL have localparam CH_W = max(1, clog2(NUM_CH)).
REQ-004 SHALL have port clk  in  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst  in  1: synchronous, active-high reset.
REQ-006 SHALL have port in_valid  in  1: input sample present.
REQ-007 SHALL have port in_ch  in  CH_W: target channel of sample.
REQ-008 SHALL have port in_data  in  32: IEEE-754 binary32 sample.
REQ-009 SHALL have port in_last  in  1: sample closes the channel's current frame.
REQ-010 SHALL have port in_ready  out  1: sample accepted when in_valid & in_ready.
REQ-011 SHALL have port out_valid  out  1: one-cycle pulse, frame sum available.
REQ-012 SHALL have port out_ch  out  CH_W: channel of the emitted sum.
REQ-013 SHALL have port out_data  out  32: binary32 frame sum.

Function
REQ-014 SHALL keep per channel: 32-bit acc, first flag (1 after reset), busy flag (0 after reset).
REQ-015 SHALL contain one binary32 adder: round-to-nearest-even, subnormal inputs/outputs flushed to signed zero, combinational core followed by ADD_LAT register stages carrying {valid, ch, last}.
REQ-016 SHALL on accept at cycle T issue add(in_data, first ? 0x80000000 : acc[in_ch]); set busy[in_ch]; clear first[in_ch].
REQ-017 SHALL write the result back at the clock edge ending cycle T+ADD_LAT: acc[ch] <= sum, busy[ch] <= 0.
REQ-018 SHALL, when the written-back op carried last, additionally set out_valid=1, out_ch=ch, out_data=sum during cycle T+ADD_LAT+1, and set first[ch]=1.
REQ-019 SHALL drive in_ready = ~busy[in_ch] combinationally; earliest re-accept on the same channel is cycle T+ADD_LAT+1.
REQ-020 SHALL accept samples to different, non-busy channels on consecutive cycles (throughput 1/cycle).
REQ-021 SHALL drive in_ready=1 when in_ch >= NUM_CH; such a sample SHALL be consumed with no state change.
REQ-022 SHALL support a writeback on channel A and an accept on channel B != A in the same cycle without interference.
REQ-023 SHALL hold out_data and out_ch between pulses; out_valid is 0 in every other cycle.
REQ-024 SHALL propagate Inf/NaN per IEEE rules; NaN output is 0x7FC00000.

Reset
REQ-025 SHALL on rst=1 set all acc=0, first=1, busy=0, pipeline valids=0, out_valid=0, out_ch=0, out_data=0.
REQ-026 SHALL discard in-flight adds on reset mid-frame; no out_valid SHALL follow for them.
REQ-027 SHALL hold in_ready=0 while rst=1.

Configuration
REQ-028 SHALL, with FP_ACC_INF_FLAG_EN defined, add port out_inf  out  1: high with out_valid if any partial sum of that frame had exponent 0xFF; per-channel sticky bit cleared on frame start and on reset.
REQ-029 SHALL, without FP_ACC_INF_FLAG_EN, have no out_inf port and no sticky logic; all other behaviour identical.

Verification
REQ-030 SHALL cover: ch0 samples 1.0, 2.0, 3.0 (last), each spaced ADD_LAT+1 cycles -> single out_valid, out_ch=0, out_data=0x40C00000.
REQ-031 SHALL cover: single-sample frame -0.0 (0x80000000, last) on ch2 -> out_data=0x80000000 at accept+ADD_LAT+1.
REQ-032 SHALL cover: ch0/ch1/ch2/ch3 interleaved every cycle, 1.0 each x4, last on 4th -> four pulses, each out_data=0x40800000, in_ready never low.
REQ-033 SHALL cover: ch1 driven every cycle -> in_ready low for exactly ADD_LAT cycles after each accept.
REQ-034 SHALL cover: rst asserted one cycle after ch0 accepts 5.0 with last -> no out_valid; next frame 1.0 (last) outputs 0x3F800000.
REQ-035 SHALL cover, with FP_ACC_INF_FLAG_EN: 0x7F7FFFFF then 0x7F7FFFFF (last) -> out_data=0x7F800000, out_inf=1; next frame 1.0 (last) -> out_inf=0.
